// File: rtl/bf_mem_arbiter.sv
// rtl/bf_mem_arbiter.sv - round-robin req/ack arbiter sharing one byte memory between fetch and data ports
// Optional watchdog on stalled memory cycles: define ARB_TIMEOUT_EN.
module bf_mem_arbiter #(
   parameter int unsigned             i_addr_width   = 16,
   parameter int unsigned             d_addr_width   = 8,
   parameter int unsigned             m_addr_width   = 17,
   parameter logic [m_addr_width-1:0] d_base         = 17'h10000,
   parameter int unsigned             timeout_cycles = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_req,
   input  logic [i_addr_width-1:0] i_addr,
   output logic                    i_ack,
   output logic [7:0]              i_rdata,
   input  logic                    d_req,
   input  logic                    d_dir,
   input  logic [d_addr_width-1:0] d_addr,
   input  logic [7:0]              d_wdata,
   output logic                    d_ack,
   output logic [7:0]              d_rdata,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [m_addr_width-1:0] mem_addr,
   output logic [7:0]              mem_wdata,
   input  logic                    mem_ack,
   input  logic [7:0]              mem_rdata,
   output logic                    arb_err
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] BUS_I  = 3'd1;
   localparam logic [2:0] BUS_D  = 3'd2;
   localparam logic [2:0] RESP_I = 3'd3;
   localparam logic [2:0] RESP_D = 3'd4;

   if (m_addr_width < i_addr_width || m_addr_width < d_addr_width) begin : g_bad_width
      $error("bf_mem_arbiter: m_addr_width smaller than a requester address");
   end
   if (timeout_cycles == 0) begin : g_bad_timeout
      $error("bf_mem_arbiter: timeout_cycles must be non-zero");
   end

   logic [2:0]              state_q, state_d;
   logic                    last_d_q, last_d_d;   // 1 = data port won the last grant
   logic                    mem_req_q, mem_req_d;
   logic                    mem_we_q, mem_we_d;
   logic [m_addr_width-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]              mem_wdata_q, mem_wdata_d;
   logic                    i_ack_q, i_ack_d;
   logic                    d_ack_q, d_ack_d;
   logic [7:0]              i_rdata_q, i_rdata_d;
   logic [7:0]              d_rdata_q, d_rdata_d;
   logic                    grant_i;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned         cnt_w   = (timeout_cycles > 255) ? $clog2(timeout_cycles + 1) : 8;
   localparam logic [cnt_w-1:0]    cnt_last = cnt_w'(timeout_cycles - 1);
   logic [cnt_w-1:0]               cnt_q, cnt_d;
   logic                           err_q, err_d;
`endif

   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_ack_d     = i_ack_q;
      d_ack_d     = d_ack_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      grant_i     = i_req && (!d_req || last_d_q);
`ifdef ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_i) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = m_addr_width'(i_addr);
               last_d_d   = 1'b0;
               state_d    = BUS_I;
`ifdef ARB_TIMEOUT_EN
               cnt_d      = '0;
`endif
            end else if (d_req) begin
               mem_req_d   = 1'b1;
               mem_we_d    = d_dir;
               mem_addr_d  = d_base + m_addr_width'(d_addr);
               mem_wdata_d = d_wdata;
               last_d_d    = 1'b1;
               state_d     = BUS_D;
`ifdef ARB_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         BUS_I: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               i_ack_d   = 1'b1;
               i_rdata_d = mem_rdata;
               state_d   = RESP_I;
`ifdef ARB_TIMEOUT_EN
            end else if (cnt_q == cnt_last) begin
               mem_req_d = 1'b0;
               i_ack_d   = 1'b1;
               i_rdata_d = 8'hFF;
               err_d     = 1'b1;
               state_d   = RESP_I;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         BUS_D: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               d_ack_d   = 1'b1;
               if (!mem_we_q) begin
                  d_rdata_d = mem_rdata;
               end
               state_d   = RESP_D;
`ifdef ARB_TIMEOUT_EN
            end else if (cnt_q == cnt_last) begin
               mem_req_d = 1'b0;
               d_ack_d   = 1'b1;
               d_rdata_d = 8'hFF;
               err_d     = 1'b1;
               state_d   = RESP_D;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         RESP_I: begin
            if (!i_req && !mem_ack) begin
               i_ack_d = 1'b0;
               state_d = IDLE;
            end
         end
         RESP_D: begin
            if (!d_req && !mem_ack) begin
               d_ack_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset-to-first-tie priority goes to fetch, hence last_d_q resets high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b1;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
`ifdef ARB_TIMEOUT_EN
   assign arb_err   = err_q;
`else
   assign arb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bf_mem_arbiter.sv
// tb/tb_bf_mem_arbiter.sv - scoreboard bench for bf_mem_arbiter (default build, watchdog disabled)
module tb_bf_mem_arbiter;

   typedef struct {
      logic        side;   // 0 = fetch, 1 = data
      logic        we;
      logic [16:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
   } txn_t;

   logic        clk, rst_n;
   logic        i_req, d_req, d_dir, mem_ack, mem_stall;
   logic [15:0] i_addr;
   logic [7:0]  d_addr, d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
   logic        i_ack, d_ack, mem_req, mem_we, arb_err;
   logic [16:0] mem_addr;

   logic        w_i_req, w_d_req, w_d_dir, w_mem_ack;
   logic [15:0] w_i_addr;
   logic [7:0]  w_d_addr, w_d_wdata, w_mem_rdata, w_i_rdata, w_d_rdata, w_mem_wdata;
   logic        w_i_ack, w_d_ack, w_mem_req, w_mem_we, w_arb_err;
   logic [16:0] w_mem_addr;

   logic [7:0]  mem_arr [0:131071];
   logic [7:0]  ref_arr [0:131071];
   logic [7:0]  exp_drd;
   int          mem_lat;
   int          n_checks, n_fail;
   txn_t        mem_q[$];
   txn_t        ack_q[$];

   bf_mem_arbiter u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .arb_err(arb_err)
   );

   bf_mem_arbiter #(.d_base(17'h1FF80)) u_wrap (
      .clk(clk), .rst_n(rst_n),
      .i_req(w_i_req), .i_addr(w_i_addr), .i_ack(w_i_ack), .i_rdata(w_i_rdata),
      .d_req(w_d_req), .d_dir(w_d_dir), .d_addr(w_d_addr), .d_wdata(w_d_wdata),
      .d_ack(w_d_ack), .d_rdata(w_d_rdata),
      .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
      .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata), .arb_err(w_arb_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push_exp(input logic side, input logic we, input logic [16:0] a, input logic [7:0] wd);
      txn_t t;
      t.side = side; t.we = we; t.addr = a; t.wdata = wd;
      if (we) begin
         ref_arr[a] = wd;
         t.rdata = exp_drd;
      end else begin
         t.rdata = ref_arr[a];
         if (side) exp_drd = t.rdata;
      end
      mem_q.push_back(t);
      ack_q.push_back(t);
   endtask

   task automatic i_run(input logic [15:0] a, input bit chk_lat);
      int n;
      i_addr = a;
      i_req  = 1'b1;
      if (chk_lat) begin
         @(negedge clk);
         check_eq("i_grant_latency", mem_req, 1'b1);
      end
      n = 0;
      while (!i_ack && n < 200) begin @(negedge clk); n++; end
      check_eq("i_ack_seen", i_ack, 1'b1);
      check_eq("d_ack_quiet", d_ack, 1'b0);
      i_addr = ~a;
      i_req  = 1'b0;
      @(negedge clk);
      check_eq("i_ack_drop", i_ack, 1'b0);
   endtask

   task automatic d_run(input logic dir, input logic [7:0] a, input logic [7:0] wd);
      int n;
      d_dir = dir; d_addr = a; d_wdata = wd;
      d_req = 1'b1;
      n = 0;
      while (!d_ack && n < 200) begin @(negedge clk); n++; end
      check_eq("d_ack_seen", d_ack, 1'b1);
      check_eq("i_ack_quiet", i_ack, 1'b0);
      d_addr = ~a; d_wdata = ~wd;
      d_req  = 1'b0;
      @(negedge clk);
      check_eq("d_ack_drop", d_ack, 1'b0);
   endtask

   // Memory responder: acks after mem_lat idle cycles, checks each access against the scoreboard.
   initial begin : mem_model
      int   wcnt;
      txn_t t;
      mem_ack = 1'b0; mem_rdata = 8'h00; wcnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mem_ack = 1'b0; wcnt = 0;
         end else if (mem_ack) begin
            if (!mem_req) mem_ack = 1'b0;
         end else if (mem_req && !mem_stall) begin
            if (wcnt < mem_lat) wcnt++;
            else begin
               wcnt = 0;
               check_eq("mem_q_nonempty", mem_q.size() != 0, 1'b1);
               if (mem_q.size() != 0) begin
                  t = mem_q.pop_front();
                  check_eq("mem_addr", mem_addr, t.addr);
                  check_eq("mem_we", mem_we, t.we);
                  if (t.we) check_eq("mem_wdata", mem_wdata, t.wdata);
               end
               if (mem_we) mem_arr[mem_addr] = mem_wdata;
               else        mem_rdata = mem_arr[mem_addr];
               mem_ack = 1'b1;
            end
         end
      end
   end

   initial begin : ack_monitor
      logic pi, pd;
      txn_t t;
      pi = 1'b0; pd = 1'b0;
      forever begin
         @(negedge clk);
         if ((i_ack && !pi) || (d_ack && !pd)) begin
            check_eq("ack_exclusive", i_ack & d_ack, 1'b0);
            check_eq("ack_q_nonempty", ack_q.size() != 0, 1'b1);
            if (ack_q.size() != 0) begin
               t = ack_q.pop_front();
               check_eq("ack_side", d_ack, t.side);
               check_eq(t.side ? "d_rdata" : "i_rdata", t.side ? d_rdata : i_rdata, t.rdata);
            end
         end
         pi = i_ack; pd = d_ack;
      end
   end

   initial begin
      int n;
      n_checks = 0; n_fail = 0; mem_lat = 0; exp_drd = 8'h00;
      for (int a = 0; a < 131072; a++) begin
         mem_arr[a] = 8'(a[7:0] * 3) ^ a[15:8] ^ {7'b0, a[16]};
         ref_arr[a] = mem_arr[a];
      end
      mem_arr[5] = 8'h2B; ref_arr[5] = 8'h2B;
      rst_n = 1'b0; mem_stall = 1'b0;
      i_req = 0; i_addr = 0; d_req = 0; d_dir = 0; d_addr = 0; d_wdata = 0;
      w_i_req = 0; w_i_addr = 0; w_d_req = 0; w_d_dir = 0; w_d_addr = 0; w_d_wdata = 0;
      w_mem_ack = 0; w_mem_rdata = 0;
      repeat (3) @(negedge clk);
      check_eq("rst_mem_req", mem_req, 1'b0);
      check_eq("rst_mem_we", mem_we, 1'b0);
      check_eq("rst_mem_addr", mem_addr, 17'h0);
      check_eq("rst_mem_wdata", mem_wdata, 8'h0);
      check_eq("rst_acks", {i_ack, d_ack}, 2'b00);
      check_eq("rst_rdata", {i_rdata, d_rdata}, 16'h0);
      check_eq("rst_arb_err", arb_err, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // Data-region address wrap on the second instance
      w_d_dir = 1'b0; w_d_addr = 8'h90; w_d_req = 1'b1;
      n = 0;
      while (!w_mem_req && n < 50) begin @(negedge clk); n++; end
      check_eq("wrap_mem_req", w_mem_req, 1'b1);
      check_eq("wrap_mem_addr", w_mem_addr, 17'h00010);
      w_mem_rdata = 8'hC3; w_mem_ack = 1'b1;
      @(negedge clk);
      check_eq("wrap_d_ack", w_d_ack, 1'b1);
      check_eq("wrap_d_rdata", w_d_rdata, 8'hC3);
      w_d_req = 1'b0; w_mem_ack = 1'b0;
      @(negedge clk);
      check_eq("wrap_d_ack_drop", w_d_ack, 1'b0);

      // Single fetch with a 2-cycle memory
      mem_lat = 2;
      push_exp(1'b0, 1'b0, 17'h00005, 8'h00);
      i_run(16'h0005, 1'b1);

      // Data write then read-back; write must leave d_rdata untouched
      mem_lat = 0;
      push_exp(1'b1, 1'b0, 17'h10010, 8'h00);
      d_run(1'b0, 8'h10, 8'h00);
      push_exp(1'b1, 1'b1, 17'h100FF, 8'h7E);
      d_run(1'b1, 8'hFF, 8'h7E);
      push_exp(1'b1, 1'b0, 17'h100FF, 8'h00);
      d_run(1'b0, 8'hFF, 8'h00);

      // Back-to-back fetches with the data side idle
      mem_lat = 1;
      for (int k = 0; k < 3; k++) begin
         push_exp(1'b0, 1'b0, {1'b0, 16'hFFF0 + 16'(k * 7)}, 8'h00);
         i_run(16'hFFF0 + 16'(k * 7), 1'b1);
      end

      // Asynchronous reset while a data read is stuck on the bus
      mem_stall = 1'b1;
      d_dir = 1'b0; d_addr = 8'h20; d_req = 1'b1;
      n = 0;
      while (!mem_req && n < 50) begin @(negedge clk); n++; end
      check_eq("abort_mem_req_up", mem_req, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("abort_mem_req", mem_req, 1'b0);
      check_eq("abort_acks", {i_ack, d_ack}, 2'b00);
      d_req = 1'b0; mem_stall = 1'b0; exp_drd = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Contention from reset: strict I, D, I, D
      mem_lat = 0;
      push_exp(1'b0, 1'b0, 17'h00100, 8'h00);
      push_exp(1'b1, 1'b0, 17'h10033, 8'h00);
      push_exp(1'b0, 1'b0, 17'h00200, 8'h00);
      push_exp(1'b1, 1'b1, 17'h10044, 8'hA9);
      fork
         begin i_run(16'h0100, 1'b0); i_run(16'h0200, 1'b0); end
         begin d_run(1'b0, 8'h33, 8'h00); d_run(1'b1, 8'h44, 8'hA9); end
      join

      repeat (4) @(negedge clk);
      check_eq("mem_q_drained", mem_q.size(), 0);
      check_eq("ack_q_drained", ack_q.size(), 0);
      check_eq("arb_err_off", arb_err, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
